// File: rtl/agc_seq_if.sv
// Control/status bundle between the receiver control FSM, the AGC
// datapath and the agc_seq sequencer.
//
// Signalling: start and stop are single-cycle request pulses with no
// acknowledge (stop wins over start); pwr_est_val is qualified by the
// one-cycle strobe pwr_est_vld and has no backpressure. The sequencer
// drives every status/control output from a flop.
interface agc_seq_if;
  logic       start;
  logic       stop;
  logic [8:0] pwr_req_val;
  logic [7:0] pwr_range;
  logic [8:0] pwr_est_val;
  logic       pwr_est_vld;
  logic       agc_en;
  logic       pwm_ena;
  logic       agc_hold;
  logic       agc_locked;
  logic       agc_fail;
  logic       lock_evt;
  logic [2:0] state;

  // Requester/datapath side: drives requests and estimates, observes status
  modport master (
    output start, stop, pwr_req_val, pwr_range, pwr_est_val, pwr_est_vld,
    input  agc_en, pwm_ena, agc_hold, agc_locked, agc_fail, lock_evt, state
  );

  // Sequencer side
  modport slave (
    input  start, stop, pwr_req_val, pwr_range, pwr_est_val, pwr_est_vld,
    output agc_en, pwm_ena, agc_hold, agc_locked, agc_fail, lock_evt, state
  );
endinterface

// File: rtl/agc_seq.sv
// AGC bring-up sequencer: settles the loop after start, tracks power
// estimates until LOCK_CNT consecutive in-range values are seen, holds the
// gain while locked, and drops back to tracking after UNLOCK_CNT
// consecutive out-of-range values. Gives up (FAIL) after TIMEOUT_EST
// estimates without lock. The state code is exported for observation.
module agc_seq #(
  parameter int SETTLE_CYC  = 64,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_CNT  = 2,
  parameter int TIMEOUT_EST = 32
) (
  input  logic      clk,
  input  logic      reset,
  agc_seq_if.slave  ifc
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int LCK_W = $clog2(LOCK_CNT + 1);
  localparam int UNL_W = $clog2(UNLOCK_CNT + 1);
  localparam int EST_W = $clog2(TIMEOUT_EST + 1);

  localparam logic [SET_W-1:0] SETTLE_V  = SET_W'(SETTLE_CYC);
  localparam logic [LCK_W-1:0] LOCK_V    = LCK_W'(LOCK_CNT);
  localparam logic [UNL_W-1:0] UNLOCK_V  = UNL_W'(UNLOCK_CNT);
  localparam logic [EST_W-1:0] TIMEOUT_V = EST_W'(TIMEOUT_EST);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_TRACK  = 3'd2,
    ST_LOCK   = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [UNL_W-1:0]   unlock_cnt_q, unlock_cnt_d;
  logic [EST_W-1:0]   est_cnt_q, est_cnt_d;
  logic [8:0]         req_q, req_d;
  logic [7:0]         range_q, range_d;

  logic agc_en_q, agc_en_d;
  logic pwm_ena_q, pwm_ena_d;
  logic agc_hold_q, agc_hold_d;
  logic agc_locked_q, agc_locked_d;
  logic agc_fail_q, agc_fail_d;
  logic lock_evt_q, lock_evt_d;

  logic [9:0] est_ext;
  logic [9:0] req_ext;
  logic [9:0] diff;
  logic       in_range;

  // Saturating increments of each counter
  logic [SET_W-1:0] settle_inc;
  logic [LCK_W-1:0] lock_inc;
  logic [UNL_W-1:0] unlock_inc;
  logic [EST_W-1:0] est_inc;

  // Absolute distance between estimate and captured request, no wrap
  always_comb begin
    est_ext  = {1'b0, ifc.pwr_est_val};
    req_ext  = {1'b0, req_q};
    diff     = (est_ext >= req_ext) ? (est_ext - req_ext) : (req_ext - est_ext);
    in_range = (diff <= {2'b00, range_q});
  end

  // Counter increments that stick at all-ones instead of wrapping
  always_comb begin
    settle_inc = (settle_cnt_q == '1) ? settle_cnt_q : settle_cnt_q + SET_W'(1);
    lock_inc   = (lock_cnt_q   == '1) ? lock_cnt_q   : lock_cnt_q   + LCK_W'(1);
    unlock_inc = (unlock_cnt_q == '1) ? unlock_cnt_q : unlock_cnt_q + UNL_W'(1);
    est_inc    = (est_cnt_q    == '1) ? est_cnt_q    : est_cnt_q    + EST_W'(1);
  end

  // Next-state, counter and capture logic; stop overrides everything
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    unlock_cnt_d = unlock_cnt_q;
    est_cnt_d    = est_cnt_q;
    req_d        = req_q;
    range_d      = range_q;

    if (ifc.stop) begin
      state_d      = ST_IDLE;
      settle_cnt_d = '0;
      lock_cnt_d   = '0;
      unlock_cnt_d = '0;
      est_cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FAIL: begin
          if (ifc.start) begin
            state_d      = ST_SETTLE;
            req_d        = ifc.pwr_req_val;
            range_d      = ifc.pwr_range;
            settle_cnt_d = '0;
            lock_cnt_d   = '0;
            unlock_cnt_d = '0;
            est_cnt_d    = '0;
          end
        end
        ST_SETTLE: begin
          // Estimates during settling are meaningless and ignored
          settle_cnt_d = settle_inc;
          if (settle_inc == SETTLE_V) begin
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (ifc.pwr_est_vld) begin
            est_cnt_d  = est_inc;
            lock_cnt_d = in_range ? lock_inc : '0;
            // A lock on the final allowed estimate still counts as lock
            if (lock_cnt_d == LOCK_V) begin
              state_d      = ST_LOCK;
              unlock_cnt_d = '0;
            end else if (est_cnt_d == TIMEOUT_V) begin
              state_d = ST_FAIL;
            end
          end
        end
        ST_LOCK: begin
          if (ifc.pwr_est_vld) begin
            unlock_cnt_d = in_range ? '0 : unlock_inc;
            if (unlock_cnt_d == UNLOCK_V) begin
              state_d      = ST_TRACK;
              lock_cnt_d   = '0;
              est_cnt_d    = '0;
              unlock_cnt_d = '0;
            end
          end
        end
        default: begin
          // Unused encodings recover to IDLE
          state_d      = ST_IDLE;
          settle_cnt_d = '0;
          lock_cnt_d   = '0;
          unlock_cnt_d = '0;
          est_cnt_d    = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered outputs
  // line up with the registered state code
  always_comb begin
    agc_en_d     = 1'b0;
    pwm_ena_d    = 1'b0;
    agc_hold_d   = 1'b0;
    agc_locked_d = 1'b0;
    agc_fail_d   = 1'b0;
    lock_evt_d   = 1'b0;
    case (state_d)
      ST_SETTLE, ST_TRACK: begin
        agc_en_d  = 1'b1;
        pwm_ena_d = 1'b1;
      end
      ST_LOCK: begin
        agc_en_d     = 1'b1;
        pwm_ena_d    = 1'b1;
        agc_hold_d   = 1'b1;
        agc_locked_d = 1'b1;
        lock_evt_d   = (state_q != ST_LOCK);
      end
      ST_FAIL: begin
        agc_fail_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counters, captured settings and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      lock_cnt_q   <= '0;
      unlock_cnt_q <= '0;
      est_cnt_q    <= '0;
      req_q        <= '0;
      range_q      <= '0;
      agc_en_q     <= 1'b0;
      pwm_ena_q    <= 1'b0;
      agc_hold_q   <= 1'b0;
      agc_locked_q <= 1'b0;
      agc_fail_q   <= 1'b0;
      lock_evt_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      unlock_cnt_q <= unlock_cnt_d;
      est_cnt_q    <= est_cnt_d;
      req_q        <= req_d;
      range_q      <= range_d;
      agc_en_q     <= agc_en_d;
      pwm_ena_q    <= pwm_ena_d;
      agc_hold_q   <= agc_hold_d;
      agc_locked_q <= agc_locked_d;
      agc_fail_q   <= agc_fail_d;
      lock_evt_q   <= lock_evt_d;
    end
  end

  assign ifc.agc_en     = agc_en_q;
  assign ifc.pwm_ena    = pwm_ena_q;
  assign ifc.agc_hold   = agc_hold_q;
  assign ifc.agc_locked = agc_locked_q;
  assign ifc.agc_fail   = agc_fail_q;
  assign ifc.lock_evt   = lock_evt_q;
  assign ifc.state      = state_q;

endmodule

// File: tb/tb_agc_seq.sv
// Testbench for agc_seq: scenario tasks drive start/stop/estimates, push
// the expected state code per strobe to exp_q and pop/compare after the
// DUT has registered its decision.
module tb_agc_seq;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  agc_seq_if ifc ();

  agc_seq #(
    .SETTLE_CYC (64),
    .LOCK_CNT   (4),
    .UNLOCK_CNT (2),
    .TIMEOUT_EST(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ifc  (ifc)
  );

  // Hard time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", checks, passed);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (inputs change on negedge) ----------------
  task automatic drive_idle();
    ifc.start       = 1'b0;
    ifc.stop        = 1'b0;
    ifc.pwr_req_val = 9'd0;
    ifc.pwr_range   = 8'd0;
    ifc.pwr_est_val = 9'd0;
    ifc.pwr_est_vld = 1'b0;
  endtask

  task automatic pulse_start(input logic [8:0] req, input logic [7:0] rng);
    ifc.pwr_req_val = req;
    ifc.pwr_range   = rng;
    ifc.start       = 1'b1;
    @(negedge clk);
    ifc.start       = 1'b0;
    // Scramble the request afterwards: only the start-cycle value may stick
    ifc.pwr_req_val = 9'($urandom_range(0, 511));
    ifc.pwr_range   = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse_stop();
    ifc.stop = 1'b1;
    @(negedge clk);
    ifc.stop = 1'b0;
  endtask

  task automatic settle_wait();
    repeat (64) @(negedge clk);
  endtask

  // Random idle gap (estimate bus noisy but not strobed), then one strobe
  task automatic send_est(input logic [8:0] v);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      ifc.pwr_est_val = 9'($urandom_range(0, 511));
      @(negedge clk);
    end
    ifc.pwr_est_val = v;
    ifc.pwr_est_vld = 1'b1;
    @(negedge clk);
    ifc.pwr_est_vld = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [2:0] exp;
    logic [8:0] outs;
    reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    outs = {ifc.state, ifc.agc_en, ifc.pwm_ena, ifc.agc_hold, ifc.agc_locked, ifc.agc_fail, ifc.lock_evt};
    checks++;
    if (outs !== 9'd0) $display("FAIL reset_outputs got=%b exp=%b", outs, 9'd0);
    else passed++;
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of TRACK with three in-range estimates counted
    pulse_start(9'h169, 8'd5);
    settle_wait();
    checks++;
    if (ifc.state !== 3'd2) $display("FAIL reset_pre_track state=%0d exp=2", ifc.state);
    else passed++;
    repeat (3) exp_q.push_back(3'd2);
    repeat (3) begin
      send_est(9'h169);
      exp = exp_q.pop_front();
      checks++;
      if (ifc.state !== exp) $display("FAIL reset_track_strobe state=%0d exp=%0d", ifc.state, exp);
      else passed++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    outs = {ifc.state, ifc.agc_en, ifc.pwm_ena, ifc.agc_hold, ifc.agc_locked, ifc.agc_fail, ifc.lock_evt};
    checks++;
    if (outs !== 9'd0) $display("FAIL reset_mid_track got=%b exp=%b", outs, 9'd0);
    else passed++;

    // Restart: counters must have been cleared, so lock needs four fresh hits
    pulse_start(9'h169, 8'd5);
    checks++;
    if (ifc.state !== 3'd1 || ifc.agc_en !== 1'b1) $display("FAIL reset_restart state=%0d en=%b exp=1/1", ifc.state, ifc.agc_en);
    else passed++;
    settle_wait();
    exp_q.push_back(3'd2); exp_q.push_back(3'd2); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    repeat (4) begin
      send_est(9'h169);
      exp = exp_q.pop_front();
      checks++;
      if (ifc.state !== exp) $display("FAIL reset_relock state=%0d exp=%0d", ifc.state, exp);
      else passed++;
    end
  endtask

  task automatic test_lock();
    logic [8:0] seq [4] = '{9'h16C, 9'h164, 9'h169, 9'h16E};
    logic [2:0] exp;
    pulse_stop();
    pulse_start(9'h169, 8'd5);
    repeat (63) @(negedge clk);
    checks++;
    if (ifc.state !== 3'd1) $display("FAIL settle_last_cycle state=%0d exp=1", ifc.state);
    else passed++;
    @(negedge clk);
    checks++;
    if (ifc.state !== 3'd2) $display("FAIL settle_done state=%0d exp=2", ifc.state);
    else passed++;
    exp_q.push_back(3'd2); exp_q.push_back(3'd2); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    for (int i = 0; i < 4; i++) begin
      send_est(seq[i]);
      exp = exp_q.pop_front();
      checks++;
      if (ifc.state !== exp) $display("FAIL lock_seq idx=%0d state=%0d exp=%0d", i, ifc.state, exp);
      else passed++;
    end
    checks++;
    if ({ifc.lock_evt, ifc.agc_hold, ifc.agc_locked, ifc.agc_en, ifc.pwm_ena} !== 5'b11111)
      $display("FAIL lock_outputs got=%b exp=11111", {ifc.lock_evt, ifc.agc_hold, ifc.agc_locked, ifc.agc_en, ifc.pwm_ena});
    else passed++;
    @(negedge clk);
    checks++;
    if (ifc.lock_evt !== 1'b0 || ifc.state !== 3'd3) $display("FAIL lock_evt_pulse evt=%b state=%0d exp=0/3", ifc.lock_evt, ifc.state);
    else passed++;
  endtask

  task automatic test_lock_count_reset();
    logic [8:0] seq_a [7] = '{9'h16C, 9'h16C, 9'h170, 9'h16C, 9'h16C, 9'h16C, 9'h16C};
    logic [8:0] seq_b [8] = '{9'h164, 9'h16E, 9'h163, 9'h16F, 9'h164, 9'h16E, 9'h164, 9'h16E};
    logic [2:0] exp;
    pulse_stop();
    pulse_start(9'h169, 8'd5);
    settle_wait();
    for (int i = 0; i < 7; i++) exp_q.push_back((i == 6) ? 3'd3 : 3'd2);
    for (int i = 0; i < 7; i++) begin
      send_est(seq_a[i]);
      exp = exp_q.pop_front();
      checks++;
      if (ifc.state !== exp) $display("FAIL lockcnt_reset idx=%0d state=%0d exp=%0d", i, ifc.state, exp);
      else passed++;
    end
    pulse_stop();
    pulse_start(9'h169, 8'd5);
    settle_wait();
    for (int i = 0; i < 8; i++) exp_q.push_back((i == 7) ? 3'd3 : 3'd2);
    for (int i = 0; i < 8; i++) begin
      send_est(seq_b[i]);
      exp = exp_q.pop_front();
      checks++;
      if (ifc.state !== exp) $display("FAIL range_boundary idx=%0d state=%0d exp=%0d", i, ifc.state, exp);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    logic [2:0] exp;
    pulse_stop();
    pulse_start(9'h169, 8'd5);
    settle_wait();
    for (int i = 0; i < 32; i++) exp_q.push_back((i == 31) ? 3'd4 : 3'd2);
    for (int i = 0; i < 32; i++) begin
      send_est(9'h100);
      exp = exp_q.pop_front();
      checks++;
      if (ifc.state !== exp) $display("FAIL timeout_seq idx=%0d state=%0d exp=%0d", i, ifc.state, exp);
      else passed++;
    end
    checks++;
    if ({ifc.agc_fail, ifc.agc_en, ifc.pwm_ena} !== 3'b100) $display("FAIL fail_outputs got=%b exp=100", {ifc.agc_fail, ifc.agc_en, ifc.pwm_ena});
    else passed++;
    // Estimates in FAIL change nothing
    repeat (4) send_est(9'h169);
    checks++;
    if (ifc.state !== 3'd4) $display("FAIL fail_hold state=%0d exp=4", ifc.state);
    else passed++;
    pulse_start(9'h169, 8'd5);
    checks++;
    if (ifc.state !== 3'd1 || ifc.agc_fail !== 1'b0 || ifc.agc_en !== 1'b1)
      $display("FAIL fail_restart state=%0d fail=%b en=%b exp=1/0/1", ifc.state, ifc.agc_fail, ifc.agc_en);
    else passed++;
    // Lock reached on the 32nd estimate beats the timeout
    settle_wait();
    for (int i = 0; i < 32; i++) exp_q.push_back((i == 31) ? 3'd3 : 3'd2);
    for (int i = 0; i < 32; i++) begin
      send_est((i < 28) ? 9'h100 : 9'h169);
      exp = exp_q.pop_front();
      checks++;
      if (ifc.state !== exp) $display("FAIL lock_vs_timeout idx=%0d state=%0d exp=%0d", i, ifc.state, exp);
      else passed++;
    end
  endtask

  task automatic test_unlock();
    logic [8:0] seq [4] = '{9'h180, 9'h169, 9'h180, 9'h180};
    logic [2:0] exp;
    exp_q.push_back(3'd3); exp_q.push_back(3'd3); exp_q.push_back(3'd3); exp_q.push_back(3'd2);
    for (int i = 0; i < 4; i++) begin
      send_est(seq[i]);
      exp = exp_q.pop_front();
      checks++;
      if (ifc.state !== exp) $display("FAIL unlock_seq idx=%0d state=%0d exp=%0d", i, ifc.state, exp);
      else passed++;
    end
    checks++;
    if ({ifc.agc_hold, ifc.agc_locked, ifc.agc_en} !== 3'b001) $display("FAIL unlock_outputs got=%b exp=001", {ifc.agc_hold, ifc.agc_locked, ifc.agc_en});
    else passed++;
    // start while tracking is ignored and must not recapture the request
    pulse_start(9'h000, 8'd0);
    checks++;
    if (ifc.state !== 3'd2) $display("FAIL start_ignored state=%0d exp=2", ifc.state);
    else passed++;
    exp_q.push_back(3'd2); exp_q.push_back(3'd2); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    repeat (4) begin
      send_est(9'h16B);
      exp = exp_q.pop_front();
      checks++;
      if (ifc.state !== exp) $display("FAIL relock_after_unlock state=%0d exp=%0d", ifc.state, exp);
      else passed++;
    end
  endtask

  task automatic test_range_edges();
    logic [2:0] exp;
    // Full-scale distance, no wrap-around
    pulse_stop();
    pulse_start(9'h000, 8'hFF);
    settle_wait();
    for (int i = 0; i < 7; i++) exp_q.push_back((i == 6) ? 3'd3 : 3'd2);
    for (int i = 0; i < 7; i++) begin
      send_est((i < 3) ? 9'h1FF : 9'h0FF);
      exp = exp_q.pop_front();
      checks++;
      if (ifc.state !== exp) $display("FAIL wide_range idx=%0d state=%0d exp=%0d", i, ifc.state, exp);
      else passed++;
    end
    // Zero tolerance means exact match only
    pulse_stop();
    pulse_start(9'h169, 8'd0);
    settle_wait();
    for (int i = 0; i < 5; i++) exp_q.push_back((i == 4) ? 3'd3 : 3'd2);
    for (int i = 0; i < 5; i++) begin
      send_est((i == 0) ? 9'h16A : 9'h169);
      exp = exp_q.pop_front();
      checks++;
      if (ifc.state !== exp) $display("FAIL zero_range idx=%0d state=%0d exp=%0d", i, ifc.state, exp);
      else passed++;
    end
  endtask

  task automatic test_start_stop();
    pulse_stop();
    checks++;
    if (ifc.state !== 3'd0 || ifc.agc_en !== 1'b0) $display("FAIL stop_from_lock state=%0d en=%b exp=0/0", ifc.state, ifc.agc_en);
    else passed++;
    ifc.start = 1'b1;
    ifc.stop  = 1'b1;
    ifc.pwr_req_val = 9'h169;
    ifc.pwr_range   = 8'd5;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.stop  = 1'b0;
    checks++;
    if (ifc.state !== 3'd0 || ifc.agc_en !== 1'b0) $display("FAIL start_stop_same state=%0d en=%b exp=0/0", ifc.state, ifc.agc_en);
    else passed++;
    pulse_start(9'h169, 8'd5);
    repeat (10) @(negedge clk);
    pulse_stop();
    checks++;
    if (ifc.state !== 3'd0 || ifc.agc_en !== 1'b0 || ifc.pwm_ena !== 1'b0)
      $display("FAIL stop_in_settle state=%0d en=%b pwm=%b exp=0/0/0", ifc.state, ifc.agc_en, ifc.pwm_ena);
    else passed++;
    // stop coinciding with an estimate strobe in TRACK wins and clears counts
    pulse_start(9'h169, 8'd5);
    settle_wait();
    repeat (3) send_est(9'h169);
    ifc.pwr_est_val = 9'h169;
    ifc.pwr_est_vld = 1'b1;
    ifc.stop        = 1'b1;
    @(negedge clk);
    ifc.pwr_est_vld = 1'b0;
    ifc.stop        = 1'b0;
    checks++;
    if (ifc.state !== 3'd0 || ifc.lock_evt !== 1'b0) $display("FAIL stop_with_strobe state=%0d evt=%b exp=0/0", ifc.state, ifc.lock_evt);
    else passed++;
    pulse_start(9'h169, 8'd5);
    settle_wait();
    send_est(9'h169);
    checks++;
    if (ifc.state !== 3'd2) $display("FAIL stop_clears_counts state=%0d exp=2", ifc.state);
    else passed++;
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    test_reset();
    test_lock();
    test_lock_count_reset();
    test_timeout();
    test_unlock();
    test_range_edges();
    test_start_stop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
